// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, then try to subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         in_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // The remainder always stays below the divisor, so a negative trial shows up in the top bit.
  always_comb begin
    shifted  = {rem, in_bit};
    trial    = shifted - {2'b00, divisor};
    q_bit    = ~trial[W+1];
    rem_next = q_bit ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Optional mthi/mtlo write ports are enabled by defining MULTDIV_MTHILO_EN.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Op,
  input  logic                  SignedOp,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
`ifdef MULTDIV_MTHILO_EN
  input  logic                  HiWe,
  input  logic                  LoWe,
  input  logic [DATA_WIDTH-1:0] WrData,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivZero,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output state_t                DbgState
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q;
  logic [W:0]      rem_q;
  logic [W-1:0]    opnd_q;
  logic            op_q;
  logic            neg_lo_q;
  logic            neg_hi_q;

  logic [W-1:0]    mag_a, mag_b;
  logic            last;
  logic            div_zero_start;
  logic [W:0]      mult_sum;
  logic [W:0]      rem_next;
  logic            q_bit;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  // Handshake: Start is a one-cycle request honoured only in IDLE (never queued);
  // Busy covers every cycle of the operation and Done pulses once when Hi/Lo are final.
  always_comb begin
    mag_a          = (SignedOp && A[W-1]) ? -A : A;
    mag_b          = (SignedOp && B[W-1]) ? -B : B;
    last           = (cnt_q == CW'(W - 1));
    div_zero_start = (Op == OP_DIV) && (B == '0);
    mult_sum       = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_fix       = neg_lo_q ? -acc_q : acc_q;
    quo_fix        = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix        = neg_hi_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  end

  div_step #(.W(W)) u_div_step (
    .rem      (rem_q),
    .in_bit   (acc_q[W-1]),
    .divisor  (opnd_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    Busy     = (state_q != IDLE);
    Done     = (state_q == DONE);
    DbgState = state_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (div_zero_start)      state_d = DONE;
          else if (Op == OP_DIV)   state_d = DIV;
          else                     state_d = MULT;
        end
      end
      MULT:    if (last) state_d = FIX;
      DIV:     if (last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiply keeps the multiplier in acc low half and the multiplicand in opnd_q;
  // divide keeps the dividend/quotient in acc low half and the divisor in opnd_q.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      op_q     <= OP_MULT;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      DivZero  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef MULTDIV_MTHILO_EN
          if (HiWe) Hi <= WrData;
          if (LoWe) Lo <= WrData;
`endif
          if (Start) begin
            DivZero  <= div_zero_start;
            op_q     <= Op;
            cnt_q    <= '0;
            rem_q    <= '0;
            neg_hi_q <= SignedOp && A[W-1];
            neg_lo_q <= SignedOp && (A[W-1] ^ B[W-1]);
            if (Op == OP_DIV) begin
              opnd_q <= mag_b;
              acc_q  <= {{W{1'b0}}, mag_a};
            end else begin
              opnd_q <= mag_a;
              acc_q  <= {{W{1'b0}}, mag_b};
            end
          end
        end
        MULT: begin
          acc_q <= {mult_sum, acc_q[W-1:1]};
          cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
        DIV: begin
          rem_q          <= rem_next;
          acc_q[W-1:0]   <= {acc_q[W-2:0], q_bit};
          cnt_q          <= last ? '0 : cnt_q + 1'b1;
        end
        FIX: begin
          if (op_q == OP_DIV) begin
            Hi <= rem_fix;
            Lo <= quo_fix;
          end else begin
            Hi <= prod_fix[2*W-1:W];
            Lo <= prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
